i2s_rx_10xe: RTL

// - I2S master-mode receiver; companion to the 10xE I2S transmitter, opposite direction.
// - Generates sclk_out and lrclk_out from aud_mclk, then deserialises 24-bit stereo samples from sdata_in.
// - Pushes each completed sample through a small FIFO onto an AXI-Stream master port.
// - Its AXI-Stream data/TID format matches what the transmitter consumes, so the two loop back directly.

---
 rtl/i2s_rx_10xe_if.sv | 13 +
 rtl/i2s_rx_10xe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/i2s_rx_10xe_if.sv
// AXI-Stream bundle carrying captured audio samples out of the I2S receiver.
interface i2s_rx_10xe_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TID_WIDTH  = 3
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [TID_WIDTH-1:0]  tid;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tid, output tvalid, input tready);
    modport slave  (input tdata, input tid, input tvalid, output tready);
endinterface

// File: rtl/i2s_rx_10xe.sv
// I2S master-mode receiver: generates sclk/lrclk from aud_mclk, deserialises stereo samples
// and streams them out through a small first-word-fall-through FIFO.
module i2s_rx_10xe #(
    parameter int unsigned AXI_STREAM_DATA_WIDTH = 32,
    parameter int unsigned AXI_STREAM_TID_WIDTH  = 3,
    parameter int unsigned SAMPLE_WIDTH          = 24,
    parameter int unsigned FIFO_DEPTH            = 4
) (
    input  logic                       aud_mclk,
    input  logic                       aud_mrst,
    input  logic                       rx_en,
    input  logic [7:0]                 sclk_div,
    input  logic                       ovf_clr,
    output logic                       sclk_out,
    output logic                       lrclk_out,
    input  logic                       sdata_in,
    i2s_rx_10xe_if.master              m_axis_aud,
    output logic                       ovf_flag,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned PadW = AXI_STREAM_DATA_WIDTH - SAMPLE_WIDTH;
    localparam logic [LvlW-1:0] Depth = LvlW'(FIFO_DEPTH);
    localparam logic [4:0] LastSlot = 5'(SAMPLE_WIDTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              div_cnt_q, div_cnt_d;
    logic [7:0]              div_q, div_d;
    logic [7:0]              div_eff;
    logic                    sclk_q, sclk_d;
    logic                    lr_q, lr_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [SAMPLE_WIDTH-1:0] push_word;
    logic                    push;

    logic [SAMPLE_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [SAMPLE_WIDTH:0]   rd_word;
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]         level_q;
    logic                    ovf_q;
    logic                    tvalid, pop, full, wr_en, ovf_set;

    assign div_eff = (sclk_div == 8'd0) ? 8'd1 : sclk_div;

    // Divider period is latched at each sclk toggle so a new sclk_div never splits a half-period.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        lr_d      = lr_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        push_word = {shift_q[SAMPLE_WIDTH-2:0], sdata_in};
        unique case (state_q)
            StIdle: begin
                div_cnt_d = '0;
                div_d     = div_eff;
                sclk_d    = 1'b0;
                lr_d      = 1'b0;
                bit_cnt_d = '0;
                shift_d   = '0;
                if (rx_en) state_d = StRun;
            end
            StRun: begin
                if (!rx_en) begin
                    state_d   = StIdle;
                    div_cnt_d = '0;
                    div_d     = div_eff;
                    sclk_d    = 1'b0;
                    lr_d      = 1'b0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (div_cnt_q == div_q - 8'd1) begin
                    div_cnt_d = '0;
                    div_d     = div_eff;
                    sclk_d    = ~sclk_q;
                    if (sclk_q) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd31) lr_d = ~lr_q;
                    end else if (bit_cnt_q != 5'd0 && bit_cnt_q <= LastSlot) begin
                        shift_d = push_word;
                        push    = (bit_cnt_q == LastSlot);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            div_q     <= 8'd1;
            sclk_q    <= 1'b0;
            lr_q      <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            lr_q      <= lr_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    assign sclk_out  = sclk_q;
    assign lrclk_out = lr_q;

    assign tvalid  = (level_q != '0);
    assign pop     = tvalid & m_axis_aud.tready;
    assign full    = (level_q == Depth);
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;
    assign rd_word = mem_q[rd_ptr_q];

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {lr_q, push_word};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (!wr_en && pop) begin
                level_q <= level_q - 1'b1;
            end
            ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
        end
    end

    assign m_axis_aud.tdata  = {rd_word[SAMPLE_WIDTH-1:0], {PadW{1'b0}}};
    assign m_axis_aud.tid    = {{(AXI_STREAM_TID_WIDTH-1){1'b0}}, rd_word[SAMPLE_WIDTH]};
    assign m_axis_aud.tvalid = tvalid;
    assign ovf_flag          = ovf_q;
    assign fifo_level        = level_q;

endmodule
